// File: rtl/sample_fifo_pkg.sv
// Shared sizing for the audio path: default sample width, FIFO depth and
// drop counter width used by sample_fifo and its neighbours.
package sample_fifo_pkg;

   localparam int D_WIDTH     = 16;
   localparam int FIFO_ADDR_W = 4;
   localparam int DROP_CNT_W  = 8;

endpackage

// File: rtl/sample_ram.sv
// Depth x d_width register file: one synchronous write port and one
// asynchronous read port. Contents are not reset.
module sample_ram
   import sample_fifo_pkg::*;
#(
   parameter int d_width    = D_WIDTH,
   parameter int addr_width = FIFO_ADDR_W
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [addr_width-1:0] waddr,
   input  logic [d_width-1:0]    wdata,
   input  logic [addr_width-1:0] raddr,
   output logic [d_width-1:0]    rdata
);

   logic [d_width-1:0] mem [2**addr_width];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sample_fifo.sv
// Elastic first-word-fall-through sample buffer in front of effect_module,
// with fill level, sticky overflow flag and a saturating drop counter.
module sample_fifo
   import sample_fifo_pkg::*;
#(
   parameter int d_width    = D_WIDTH,
   parameter int addr_width = FIFO_ADDR_W,
   parameter int cnt_width  = DROP_CNT_W
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  i_valid,
   input  logic [d_width-1:0]    i_sample,
   output logic                  o_data_ready,
   output logic [d_width-1:0]    o_data,
   input  logic                  i_read_enable,
   output logic                  o_full,
   output logic [addr_width:0]   o_level,
   output logic [cnt_width-1:0]  o_drop_count,
   output logic                  o_overflow
);

   localparam logic [addr_width:0]  ptr_one = 1;
   localparam logic [cnt_width-1:0] cnt_one = 1;

   logic [addr_width:0]  wr_ptr;
   logic [addr_width:0]  rd_ptr;
   logic [cnt_width-1:0] drop_count;
   logic                 overflow;
   logic                 empty;
   logic                 full;
   logic                 pop;
   logic                 push;
   logic                 drop;
   logic [d_width-1:0]   head;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[addr_width] != rd_ptr[addr_width]) &&
                  (wr_ptr[addr_width-1:0] == rd_ptr[addr_width-1:0]);

   // Handshake: upstream i_valid is a one-cycle strobe with no backpressure, so
   // a sample arriving while full with no pop is dropped. Downstream pops the
   // head at a posedge only when o_data_ready (=!empty) and i_read_enable are
   // both high; a read_enable while empty is ignored.
   assign pop  = i_read_enable && !empty;
   assign push = i_valid && (!full || pop);
   assign drop = i_valid && full && !pop;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         drop_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ptr_one;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + ptr_one;
         end
         if (drop) begin
            overflow <= 1'b1;
            if (!(&drop_count)) begin
               drop_count <= drop_count + cnt_one;
            end
         end
      end
   end

   sample_ram #(
      .d_width    (d_width),
      .addr_width (addr_width)
   ) u_ram (
      .clk   (clk),
      .we    (push && reset),
      .waddr (wr_ptr[addr_width-1:0]),
      .wdata (i_sample),
      .raddr (rd_ptr[addr_width-1:0]),
      .rdata (head)
   );

   assign o_data_ready = !empty;
   assign o_data       = empty ? '0 : head;
   assign o_full       = full;
   assign o_level      = wr_ptr - rd_ptr;
   assign o_drop_count = drop_count;
   assign o_overflow   = overflow;

endmodule
